// File: rtl/config_chain_pkg.sv
// Shared types for the configuration-chain loader: FSM state encoding and counter sizing.
package config_chain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Wide enough to hold the value CHAIN_LENGTH itself, not just CHAIN_LENGTH-1.
    function automatic int cnt_width(input int chain_length);
        return $clog2(chain_length + 1);
    endfunction

endpackage

// File: rtl/ccff_serializer.sv
// Parallel-load, MSB-first shift register with a quota down-counter; one bit per shift cycle.
// Load takes effect on the next edge; the shift input is honoured only while quota is non-zero.
module ccff_serializer #(
    parameter int WORD_WIDTH  = 8,
    parameter int QUOTA_WIDTH = $clog2(WORD_WIDTH + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_load,
    input  logic [WORD_WIDTH-1:0]  i_word,
    input  logic [QUOTA_WIDTH-1:0] i_quota,
    input  logic                   i_shift,
    output logic                   o_msb,
    output logic                   o_last,
    output logic                   o_empty
);

    logic [WORD_WIDTH-1:0]  r_sreg;
    logic [QUOTA_WIDTH-1:0] r_quota;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sreg  <= '0;
            r_quota <= '0;
        end else if (i_load) begin
            r_sreg  <= i_word;
            r_quota <= i_quota;
        end else if (i_shift && (r_quota != '0)) begin
            r_sreg  <= r_sreg << 1;
            r_quota <= r_quota - 1'b1;
        end
    end

    assign o_msb   = r_sreg[WORD_WIDTH-1];
    assign o_last  = (r_quota == QUOTA_WIDTH'(1));
    assign o_empty = (r_quota == '0);

endmodule

// File: rtl/config_chain_loader.sv
// Loads CHAIN_LENGTH config bits MSB-first onto ccff_head; first bit one cycle after word accept.
// word_ready only in LOAD (one bubble per word); a stalled source just holds the FSM in LOAD.
module config_chain_loader
    import config_chain_pkg::*;
#(
    parameter int WORD_WIDTH   = 8,
    parameter int CHAIN_LENGTH = 64,
    parameter int CNT_WIDTH    = cnt_width(CHAIN_LENGTH)
) (
    input  logic                  prog_clk,
    input  logic                  pReset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  ccff_head,
    output logic                  shift_en,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  bits_loaded
);

    localparam int QW = $clog2(WORD_WIDTH + 1);

    state_t               r_state;
    state_t               w_next_state;
    logic [CNT_WIDTH-1:0] r_bits_loaded;
    logic [CNT_WIDTH-1:0] w_remaining;
    logic [CNT_WIDTH-1:0] w_bits_next;
    logic [QW-1:0]        w_quota;
    logic                 w_load;
    logic                 w_shift;
    logic                 w_msb;
    logic                 w_last;
    logic                 w_empty;

    ccff_serializer #(
        .WORD_WIDTH  (WORD_WIDTH),
        .QUOTA_WIDTH (QW)
    ) u_serializer (
        .i_clk   (prog_clk),
        .i_rst   (pReset),
        .i_load  (w_load),
        .i_word  (word_data),
        .i_quota (w_quota),
        .i_shift (w_shift),
        .o_msb   (w_msb),
        .o_last  (w_last),
        .o_empty (w_empty)
    );

    assign w_remaining = CNT_WIDTH'(CHAIN_LENGTH) - r_bits_loaded;
    assign w_bits_next = r_bits_loaded + 1'b1;

    // The final word of a non-multiple chain only gets its upper bits shifted.
    always_comb begin
        w_quota = QW'(WORD_WIDTH);
        if (int'(w_remaining) < WORD_WIDTH) begin
            w_quota = QW'(w_remaining);
        end
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_bits_loaded <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_bits_loaded <= '0;
        end else if (w_shift) begin
            r_bits_loaded <= w_bits_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (word_valid) begin
                    w_load       = 1'b1;
                    w_next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_empty) begin
                    w_next_state = ST_LOAD;
                end else begin
                    w_shift = 1'b1;
                    if (w_last) begin
                        w_next_state = (w_bits_next == CNT_WIDTH'(CHAIN_LENGTH)) ? ST_DONE : ST_LOAD;
                    end
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign word_ready  = (r_state == ST_LOAD);
    assign shift_en    = w_shift;
    assign ccff_head   = w_shift & w_msb;
    assign busy        = (r_state == ST_LOAD) || (r_state == ST_SHIFT);
    assign done        = (r_state == ST_DONE);
    assign bits_loaded = r_bits_loaded;

endmodule

// File: tb/tb_config_chain_loader.sv
// Scoreboard bench: two loader instances (12-bit and 16-bit chains) share stimulus, gated by sel.
module tb_config_chain_loader;

    logic       prog_clk = 1'b0;
    logic       pReset;
    logic       start;
    logic       word_valid;
    logic       sel;
    logic [7:0] word_data;

    always #5 prog_clk = ~prog_clk;

    logic       wr12, head12, se12, busy12, done12;
    logic [3:0] bl12;
    logic       wr16, head16, se16, busy16, done16;
    logic [4:0] bl16;

    config_chain_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(12)) dut12 (
        .prog_clk    (prog_clk),
        .pReset      (pReset),
        .start       (start & ~sel),
        .word_data   (word_data),
        .word_valid  (word_valid & ~sel),
        .word_ready  (wr12),
        .ccff_head   (head12),
        .shift_en    (se12),
        .busy        (busy12),
        .done        (done12),
        .bits_loaded (bl12)
    );

    config_chain_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(16)) dut16 (
        .prog_clk    (prog_clk),
        .pReset      (pReset),
        .start       (start & sel),
        .word_data   (word_data),
        .word_valid  (word_valid & sel),
        .word_ready  (wr16),
        .ccff_head   (head16),
        .shift_en    (se16),
        .busy        (busy16),
        .done        (done16),
        .bits_loaded (bl16)
    );

    wire       m_ready = sel ? wr16   : wr12;
    wire       m_head  = sel ? head16 : head12;
    wire       m_se    = sel ? se16   : se12;
    wire       m_busy  = sel ? busy16 : busy12;
    wire       m_done  = sel ? done16 : done12;
    wire [4:0] m_bl    = sel ? bl16   : {1'b0, bl12};

    // Model chains: index 0 sits next to the head.
    logic [11:0] chain12;
    logic [15:0] chain16;
    always @(posedge prog_clk) begin
        if (se12) chain12 <= {chain12[10:0], head12};
        if (se16) chain16 <= {chain16[14:0], head16};
    end

    typedef struct {
        int          nbits;
        logic [15:0] chain;
    } done_t;

    bit    exp_bits[$];
    done_t exp_done[$];
    int    checks = 0;
    int    failures = 0;
    int    shift_cnt = 0;
    bit    prev_shift = 1'b0;
    bit    mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) exp_bits.push_back(v[i]);
    endtask

    task automatic push_done(input int n, input logic [15:0] c);
        done_t d;
        d.nbits = n;
        d.chain = c;
        exp_done.push_back(d);
    endtask

    // Monitor: pops expected bits on every shift cycle and expected completions on done.
    always @(negedge prog_clk) begin
        if (mon_en) begin
            if (m_se) begin
                if (exp_bits.size() == 0) begin
                    check("unexpected_shift", 1, 0);
                end else begin
                    check("ccff_head", m_head, exp_bits.pop_front());
                end
                shift_cnt++;
            end else begin
                check("head_idle_zero", m_head, 0);
            end
            if (m_done) begin
                if (exp_done.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    done_t d;
                    d = exp_done.pop_front();
                    check("done_bits_loaded", m_bl, d.nbits);
                    check("shift_count", shift_cnt, d.nbits);
                    check("done_after_last_shift", prev_shift, 1);
                    check("chain_contents", sel ? chain16 : {4'b0, chain12}, d.chain);
                end
                shift_cnt = 0;
            end
            prev_shift = m_se;
        end
    end

    task automatic kick();
        @(negedge prog_clk);
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        check("busy_after_start", m_busy, 1);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!m_ready && n < 200) begin
            @(negedge prog_clk);
            n++;
        end
        if (n >= 200) check("ready_timeout", 0, 1);
    endtask

    task automatic send(input logic [7:0] w, input int gap, input bit hold);
        if (gap > 0) begin
            word_valid = 1'b0;
            wait_ready();
            repeat (gap) begin
                @(negedge prog_clk);
                check("gap_shift_en", m_se, 0);
                check("gap_word_ready", m_ready, 1);
            end
        end
        word_data  = w;
        word_valid = 1'b1;
        wait_ready();
        @(posedge prog_clk);
        @(negedge prog_clk);
        if (!hold) word_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!m_done && n < 300) begin
            @(negedge prog_clk);
            n++;
        end
        if (n >= 300) check("done_timeout", 0, 1);
        @(negedge prog_clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pReset     = 1'b1;
        start      = 1'b0;
        word_valid = 1'b0;
        word_data  = 8'h00;
        sel        = 1'b0;

        // Reset with start held and random data/valid.
        repeat (2) begin
            @(negedge prog_clk);
            start      = 1'b1;
            word_valid = 1'($urandom);
            word_data  = 8'($urandom);
            @(negedge prog_clk);
            check("reset_outs12", {wr12, head12, se12, busy12, done12, bl12}, 0);
            check("reset_outs16", {wr16, head16, se16, busy16, done16, bl16}, 0);
        end
        pReset     = 1'b0;
        start      = 1'b0;
        word_valid = 1'b0;
        @(negedge prog_clk);
        check("idle_after_reset", {wr12, busy12, se12, done12}, 0);
        mon_en = 1'b1;

        // Partial final word, valid held high.
        push_bits(16'h0A53, 12);
        push_done(12, 16'h0A53);
        kick();
        send(8'hA5, 0, 1'b1);
        send(8'h3C, 0, 1'b0);
        wait_done();

        // Back-pressure: 3 idle cycles before each word.
        push_bits(16'h0A53, 12);
        push_done(12, 16'h0A53);
        kick();
        send(8'hA5, 3, 1'b0);
        send(8'h3C, 3, 1'b0);
        wait_done();

        // Reset on the 5th shift cycle of the first word.
        push_bits(16'h0014, 5);
        kick();
        send(8'hA5, 0, 1'b0);
        repeat (4) @(negedge prog_clk);
        pReset = 1'b1;
        @(negedge prog_clk);
        check("midreset_shift_en", se12, 0);
        check("midreset_busy", busy12, 0);
        check("midreset_bits_loaded", bl12, 0);
        check("midreset_done", done12, 0);
        pReset    = 1'b0;
        shift_cnt = 0;
        push_bits(16'h0A53, 12);
        push_done(12, 16'h0A53);
        kick();
        send(8'hA5, 0, 1'b1);
        send(8'h3C, 0, 1'b0);
        wait_done();

        // Exact multiple on the 16-bit chain.
        sel = 1'b1;
        push_bits(16'hFF00, 16);
        push_done(16, 16'hFF00);
        kick();
        send(8'hFF, 0, 1'b1);
        send(8'h00, 0, 1'b0);
        wait_done();

        // Spurious start pulses during SHIFT and DONE.
        push_bits(16'hFF00, 16);
        push_done(16, 16'hFF00);
        fork
            begin
                kick();
                send(8'hFF, 0, 1'b1);
                send(8'h00, 0, 1'b0);
            end
            begin
                int n = 0;
                while (!m_se && n < 300) begin
                    @(negedge prog_clk);
                    n++;
                end
                start = 1'b1;
                @(negedge prog_clk);
                start = 1'b0;
                n = 0;
                while (!m_done && n < 300) begin
                    @(negedge prog_clk);
                    n++;
                end
                if (n >= 300) check("spurious_done_timeout", 0, 1);
                start = 1'b1;
                @(negedge prog_clk);
                start = 1'b0;
            end
        join
        repeat (5) @(negedge prog_clk);
        check("spurious_no_restart_busy", m_busy, 0);
        check("spurious_no_restart_ready", m_ready, 0);

        check("exp_bits_drained", exp_bits.size(), 0);
        check("exp_done_drained", exp_done.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/config_chain_loader.md
Name: config_chain_loader

Overview:
- Programming-side writer that loads configuration bits into a configuration-chain shift register.
- Those chain flip-flops drive the select ports (S0/S) of the routing, LUT and carry multiplexer cells.
- Accepts parallel bitstream words over a valid/ready handshake and serializes them onto ccff_head, with a shift enable, for exactly CHAIN_LENGTH bits.
- Signals completion with a one-cycle pulse. Sits between the bitstream source (testbench or on-chip loader) and the fabric's chain head.

Parameters:
- WORD_WIDTH, 8: bits per input word.
- CHAIN_LENGTH, 64: total configuration bits in the chain; must be >= 1.
- CNT_WIDTH, $clog2(CHAIN_LENGTH+1): width of the bit counter. Derived; do not override.

Ports:
- prog_clk  input  1  programming clock; the only clock.
- pReset  input  1  synchronous, active-high reset.
- start  input  1  begin a load; sampled only in IDLE.
- word_data  input  WORD_WIDTH  bitstream word.
- word_valid  input  1  word_data valid.
- word_ready  output  1  loader can accept a word this cycle.
- ccff_head  output  1  serial bit to the chain head.
- shift_en  output  1  chain flip-flops capture ccff_head on this prog_clk edge.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse after the last bit is shifted.
- bits_loaded  output  CNT_WIDTH  bits shifted so far in the current load.

Behaviour:
- **Reset.** pReset is synchronous: on a prog_clk edge with pReset=1:
  - state goes to IDLE;
  - word_ready, shift_en, busy, done, ccff_head = 0;
  - bits_loaded = 0; shift register cleared.
- **Reset mid-load.** Aborts immediately. shift_en is 0 from the next cycle, and the partial chain contents are left as-is.
- **States:** IDLE, LOAD, SHIFT, DONE.
- **IDLE:** start=1 -> LOAD; bits_loaded cleared to 0; busy=1 from the next cycle.
- **LOAD:**
  - word_ready=1 (combinational on state).
  - Handshake: when word_valid && word_ready, capture word_data into the shift register, compute the word's bit quota, and go to SHIFT.
  - word_valid=0 -> stay in LOAD; there is no timeout.
- **Bit quota:** min(WORD_WIDTH, CHAIN_LENGTH - bits_loaded).
- **SHIFT:**
  - shift_en=1; ccff_head = shift register MSB (word_data[WORD_WIDTH-1] of the word goes out first).
  - Each cycle: shift left by 1, bits_loaded += 1, quota -= 1.
  - When the last quota bit shifts: bits_loaded == CHAIN_LENGTH -> DONE; otherwise -> LOAD.
- **Partial final word.** When CHAIN_LENGTH is not a multiple of WORD_WIDTH, only the upper (quota) bits of the final word are shifted. Its low bits are discarded.
- **DONE:** done=1 for exactly one cycle, busy=0, then IDLE.
- **Timing:**
  - word_ready is 0 in SHIFT, so there is one bubble cycle per word.
  - A word accepted at edge N drives its first shifted bit in the cycle after edge N.
- **Outputs:** ccff_head and shift_en are derived only from state and registers. No input-to-output combinational path exists except none; word_ready depends on state only.
- **start outside IDLE** (LOAD, SHIFT, DONE): ignored. No restart and no error.
- **word_valid outside LOAD:** ignored; the source must hold the word until ready.
- **ccff_head when shift_en=0:** 0.
- **CHAIN_LENGTH=1:** one word accepted, one shift, then DONE.
- **Ordering:** after a complete load, the first bit shifted sits in the chain's last flip-flop (farthest from head). The bit stream order is the reverse of chain position order, and the bitstream generator owns that ordering.

Decomposition:
- **Package config_chain_pkg:**
  - state enum (IDLE, LOAD, SHIFT, DONE);
  - localparam function for CNT_WIDTH.
- **One sub-module, ccff_serializer:** WORD_WIDTH parallel-load, MSB-first shift register with a quota down-counter. It has load, shift and empty outputs. The FSM and the bit counter stay in the top level.

Test Plan:
- **Reset values.** pReset=1 for 2 cycles with random inputs -> all outputs 0, state IDLE; start held during reset is ignored.
- **Partial final word.** CHAIN_LENGTH=12, WORD_WIDTH=8; start, then words 0xA5 and 0x3C with valid held high:
  - ccff_head over the 12 shift_en cycles = 1,0,1,0,0,1,0,1,0,0,1,1;
  - a 12-flop model chain holds that sequence;
  - done pulses once, bits_loaded=12, and the 0x3C low nibble is never shifted.
- **Back-pressure.** Same config with 3 idle cycles before each word_valid -> LOAD holds, shift_en=0 during the gaps, and the final chain contents are identical.
- **Exact multiple.** CHAIN_LENGTH=16, words 0xFF, 0x00 -> exactly 16 shift_en cycles, chain = eight 1s then eight 0s, done 1 cycle after the last shift.
- **Reset mid-load.** Assert pReset on the 5th shift cycle of word 1 -> shift_en=0 and busy=0 next cycle, bits_loaded=0, no done pulse. A new start then loads correctly.
- **Spurious start.** start pulses during SHIFT and DONE -> no effect; exactly one done per accepted start.
